// File: rtl/or_stim_checker_if.sv
// ----------------------------------------------------------------------------
// or_stim_checker_if
// Bundles the signals between the OR-gate stimulus checker and its environment.
//   start     : run request (environment -> checker)
//   dut_out   : output of the OR gate under test (environment -> checker)
//   in1, in2  : registered stimulus driven onto the gate inputs
//   busy      : a run is in progress
//   done      : run finished; pass/err_count hold the result
//   pass      : run had no mismatches (meaningful while done = 1)
//   err_count : saturating mismatch count for the current or last run
//   vec_idx   : index of the vector currently applied
// master: the environment side.  slave: the checker side.
// ----------------------------------------------------------------------------
interface or_stim_checker_if;
   logic       start;
   logic       dut_out;
   logic       in1;
   logic       in2;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [1:0] vec_idx;

   modport master (
      output start, dut_out,
      input  in1, in2, busy, done, pass, err_count, vec_idx
   );

   modport slave (
      input  start, dut_out,
      output in1, in2, busy, done, pass, err_count, vec_idx
   );
endinterface

// File: rtl/or_stim_checker.sv
// ----------------------------------------------------------------------------
// or_stim_checker
// Exhaustively exercises a 2-input OR gate: applies the four input vectors
// NUM_PASSES times, waits SETTLE_CYCLES after each, then compares the gate
// output with the expected OR value and counts mismatches (saturating at 255).
// Ports:
//   clk   : single clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : or_stim_checker_if.slave (start, dut_out in; in1, in2, busy, done,
//           pass, err_count, vec_idx out -- all outputs registered)
// Parameters:
//   SETTLE_CYCLES : settle time per vector, 1..15
//   NUM_PASSES    : full 4-vector sweeps per run, 1..255
// ----------------------------------------------------------------------------
module or_stim_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 4
) (
   input logic               clk,
   input logic               rst_n,
   or_stim_checker_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

   state_t     r_state;
   logic       r_in1;
   logic       r_in2;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [7:0] r_err_count;
   logic [1:0] r_vec_idx;
   logic [7:0] r_pass_cnt;
   logic [3:0] r_settle_cnt;

   logic [7:0] w_err_next;
   logic [1:0] w_vec_next;
   logic       w_last_vec;

   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      w_err_next = r_err_count;
      w_vec_next = r_vec_idx + 2'd1;
      w_last_vec = (r_vec_idx == 2'd3) && (r_pass_cnt == LAST_PASS);
      // Only consumed in CHECK, so dut_out is effectively ignored elsewhere.
      if ((bus.dut_out != (r_in1 | r_in2)) && (r_err_count != 8'hFF))
         w_err_next = r_err_count + 8'd1;
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_in1        <= 1'b0;
         r_in2        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= 8'd0;
         r_vec_idx    <= 2'd0;
         r_pass_cnt   <= 8'd0;
         r_settle_cnt <= 4'd0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  // Fresh run: vector 0 (in1 = in2 = 0) goes out on this edge.
                  r_state     <= DRIVE;
                  r_in1       <= 1'b0;
                  r_in2       <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_err_count <= 8'd0;
                  r_vec_idx   <= 2'd0;
                  r_pass_cnt  <= 8'd0;
               end
            end

            DRIVE: begin
               r_state      <= SETTLE;
               r_settle_cnt <= SETTLE_INIT;
            end

            SETTLE: begin
               // Counter is loaded with SETTLE_CYCLES, so leaving at 1 gives
               // exactly SETTLE_CYCLES cycles in this state.
               r_settle_cnt <= r_settle_cnt - 4'd1;
               if (r_settle_cnt == 4'd1)
                  r_state <= CHECK;
            end

            CHECK: begin
               r_err_count <= w_err_next;
               if (w_last_vec) begin
                  r_state   <= DONE;
                  r_in1     <= 1'b0;
                  r_in2     <= 1'b0;
                  r_vec_idx <= 2'd0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_pass    <= (w_err_next == 8'd0);
               end else begin
                  r_state   <= DRIVE;
                  r_vec_idx <= w_vec_next;
                  r_in1     <= w_vec_next[0];
                  r_in2     <= w_vec_next[1];
                  if (r_vec_idx == 2'd3)
                     r_pass_cnt <= r_pass_cnt + 8'd1;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in1       = r_in1;
   assign bus.in2       = r_in2;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.err_count = r_err_count;
   assign bus.vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_or_stim_checker.sv
// ----------------------------------------------------------------------------
// tb_or_stim_checker
// Two checker instances: A at defaults (4 passes), B with 100 passes.  The gate
// under test is modelled as (in1 | in2) XOR a fault mask indexed by the applied
// vector, so ideal, stuck-at-0, stuck-at-1 and random faulty gates are all one
// model.  Each run pushes its expected result (error count, pass, done edge)
// into a per-instance queue; monitors pop and compare whenever done rises.
// ----------------------------------------------------------------------------
module tb_or_stim_checker;

   localparam int S     = 2;
   localparam int NP_A  = 4;
   localparam int NP_B  = 100;
   localparam int LAT_A = 4 * NP_A * (S + 2);
   localparam int LAT_B = 4 * NP_B * (S + 2);

   typedef struct {
      int unsigned err;
      bit          pass;
      int          done_edge;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n_a = 1'b0;
   logic       rst_n_b = 1'b0;
   int         cyc = 0;
   logic [3:0] mask_a = 4'd0;
   logic [3:0] mask_b = 4'd0;

   exp_t sb_a[$];
   exp_t sb_b[$];

   int   n_pass  = 0;
   int   n_total = 0;
   int   run_start_a = 0;
   int   run_end_a   = 0;
   logic done_q_a = 1'b0;
   logic done_q_b = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   or_stim_checker_if u_if_a ();
   or_stim_checker_if u_if_b ();

   // Faulty-gate model: flips the OR result for vectors selected by the mask.
   assign u_if_a.dut_out = (u_if_a.in1 | u_if_a.in2) ^ mask_a[{u_if_a.in2, u_if_a.in1}];
   assign u_if_b.dut_out = (u_if_b.in1 | u_if_b.in2) ^ mask_b[{u_if_b.in2, u_if_b.in1}];

   or_stim_checker #(.SETTLE_CYCLES(S), .NUM_PASSES(NP_A)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n_a),
      .bus   (u_if_a)
   );

   or_stim_checker #(.SETTLE_CYCLES(S), .NUM_PASSES(NP_B)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (u_if_b)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: count vectors whose observed output differs from a|b.
   function automatic exp_t model(input int passes, input logic [3:0] mask, input int start_edge);
      exp_t e;
      int   mism = 0;
      for (int p = 0; p < passes; p++) begin
         for (int v = 0; v < 4; v++) begin
            bit good     = v[0] | v[1];
            bit observed = good ^ mask[v];
            if (observed != good) mism++;
         end
      end
      e.err       = (mism > 255) ? 255 : mism;
      e.pass      = (mism == 0);
      e.done_edge = start_edge + passes * 4 * (S + 2);
      return e;
   endfunction

   function automatic logic [14:0] pack_a();
      return {u_if_a.in1, u_if_a.in2, u_if_a.busy, u_if_a.done, u_if_a.pass,
              u_if_a.err_count, u_if_a.vec_idx};
   endfunction

   function automatic logic [14:0] pack_b();
      return {u_if_b.in1, u_if_b.in2, u_if_b.busy, u_if_b.done, u_if_b.pass,
              u_if_b.err_count, u_if_b.vec_idx};
   endfunction

   // Scoreboard + vector-sequence monitor for instance A.
   always @(negedge clk) begin : mon_a
      exp_t e;
      int   k;
      if (u_if_a.done && !done_q_a) begin
         if (sb_a.size() == 0) begin
            check("a_unexpected_done", sb_a.size(), 1);
         end else begin
            e = sb_a.pop_front();
            check("a_err_count", u_if_a.err_count, e.err);
            check("a_pass", u_if_a.pass, e.pass);
            check("a_done_edge", cyc, e.done_edge);
            check("a_done_idle_outs", {u_if_a.in1, u_if_a.in2, u_if_a.vec_idx, u_if_a.busy}, 0);
         end
      end
      if (cyc >= run_start_a && cyc < run_end_a) begin
         k = ((cyc - run_start_a) / (S + 2)) % 4;
         check("a_busy", u_if_a.busy, 1);
         check("a_done_low", u_if_a.done, 0);
         check("a_vector", {u_if_a.in2, u_if_a.in1}, k);
         check("a_vec_idx", u_if_a.vec_idx, k);
      end
      done_q_a <= u_if_a.done;
   end

   // Scoreboard for instance B.
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (u_if_b.done && !done_q_b) begin
         if (sb_b.size() == 0) begin
            check("b_unexpected_done", sb_b.size(), 1);
         end else begin
            e = sb_b.pop_front();
            check("b_err_count", u_if_b.err_count, e.err);
            check("b_pass", u_if_b.pass, e.pass);
            check("b_done_edge", cyc, e.done_edge);
         end
      end
      done_q_b <= u_if_b.done;
   end

   task automatic drain(input bit which, input int budget);
      for (int i = 0; i < budget && (which ? sb_b.size() : sb_a.size()) != 0; i++)
         @(negedge clk);
      @(negedge clk);
      if (which) check("b_drain", sb_b.size(), 0);
      else       check("a_drain", sb_a.size(), 0);
   endtask

   task automatic run_a(input logic [3:0] m);
      int s;
      mask_a = m;
      @(negedge clk);
      u_if_a.start = 1'b1;
      s = cyc + 1;
      sb_a.push_back(model(NP_A, m, s));
      run_start_a = s;
      run_end_a   = s + LAT_A;
      @(negedge clk);
      u_if_a.start = 1'b0;
      drain(1'b0, LAT_A + 20);
   endtask

   task automatic run_b(input logic [3:0] m);
      mask_b = m;
      @(negedge clk);
      u_if_b.start = 1'b1;
      sb_b.push_back(model(NP_B, m, cyc + 1));
      @(negedge clk);
      u_if_b.start = 1'b0;
      drain(1'b1, LAT_B + 20);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, s1, s2, d1;
      u_if_a.start = 1'b1;
      u_if_b.start = 1'b1;

      // Reset held with start asserted: everything stays cleared.
      repeat (3) @(negedge clk);
      check("a_reset_outs", pack_a(), 0);
      check("b_reset_outs", pack_b(), 0);
      u_if_a.start = 1'b0;
      u_if_b.start = 1'b0;
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      repeat (3) @(negedge clk);
      check("a_idle_outs", pack_a(), 0);
      check("b_idle_outs", pack_b(), 0);

      fork
         begin
            // Ideal, stuck-at-0, stuck-at-1, then random faulty gates.
            run_a(4'b0000);
            run_a(4'b1110);
            run_a(4'b0001);
            for (int i = 0; i < 4; i++) run_a(4'($urandom_range(0, 15)));

            // Abort during SETTLE of vector 2, then a clean full run.
            mask_a = 4'($urandom_range(0, 15));
            @(negedge clk);
            u_if_a.start = 1'b1;
            s = cyc + 1;
            run_start_a = s;
            run_end_a   = s + LAT_A;
            @(negedge clk);
            u_if_a.start = 1'b0;
            while (cyc < s + 9) @(negedge clk);
            #2;
            run_end_a = cyc;
            rst_n_a = 1'b0;
            #1;
            check("a_abort_outs", pack_a(), 0);
            @(negedge clk);
            rst_n_a = 1'b1;
            repeat (2) @(negedge clk);
            check("a_after_abort_outs", pack_a(), 0);
            run_a(4'b0000);

            // start held high: no restart until DONE, then immediate restart.
            mask_a = 4'b1110;
            @(negedge clk);
            u_if_a.start = 1'b1;
            s1 = cyc + 1;
            d1 = s1 + LAT_A;
            s2 = d1 + 1;
            sb_a.push_back(model(NP_A, mask_a, s1));
            sb_a.push_back(model(NP_A, mask_a, s2));
            run_start_a = s1;
            run_end_a   = d1;
            while (cyc < d1) @(negedge clk);
            run_start_a = s2;
            run_end_a   = s2 + LAT_A;
            @(negedge clk);
            check("a_restart_done", u_if_a.done, 0);
            check("a_restart_err", u_if_a.err_count, 0);
            check("a_restart_busy", u_if_a.busy, 1);
            u_if_a.start = 1'b0;
            drain(1'b0, LAT_A + 20);
         end
         begin
            // 100 passes stuck-at-0: 300 mismatches saturate at 255.
            run_b(4'b1110);
            run_b(4'($urandom_range(0, 15)));
         end
      join

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/or_stim_checker.md
OR_STIM_CHECKER -- requirements
Module: or_stim_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles the DUT output settles after each vector is applied; legal range 1..15.
REQ-002 Parameter NUM_PASSES, default 4: number of full 4-vector sweeps per run; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  run request; sampled only in IDLE and DONE.
REQ-006 dut_out  input  1  output of the 2-input OR gate under test.
REQ-007 in1  output  1  stimulus to the gate's first input, registered.
REQ-008 in2  output  1  stimulus to the gate's second input, registered.
REQ-009 busy  output  1  high in DRIVE, SETTLE and CHECK.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  valid while done = 1; 1 iff err_count = 0.
REQ-012 err_count  output  8  mismatch count for the current or last run; saturating.
REQ-013 vec_idx  output  2  index of the vector currently applied.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 IDLE: in1 = in2 = 0; start = 1 -> DRIVE, clearing err_count, vec_idx and pass counter.
REQ-016 DONE: start = 1 -> DRIVE with the same clears as IDLE; otherwise remain in DONE.
REQ-017 Vector order SHALL be in1 = vec_idx[0], in2 = vec_idx[1]: 00, 01, 10, 11 (in1 toggles every vector, in2 every second vector).
REQ-018 in1/in2 SHALL update on the edge entering DRIVE and hold through DRIVE, SETTLE and CHECK.
REQ-019 DRIVE SHALL last 1 cycle, then -> SETTLE with settle counter loaded to SETTLE_CYCLES.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> CHECK.
REQ-021 CHECK SHALL last 1 cycle and compare dut_out against in1 OR in2; on mismatch, err_count increments by 1, saturating at 255.
REQ-022 After CHECK: if vec_idx = 3 and pass counter = NUM_PASSES-1 -> DONE; else vec_idx increments (3 wraps to 0, pass counter +1) -> DRIVE.
REQ-023 Each vector SHALL take SETTLE_CYCLES+2 cycles; done SHALL rise on the 4*NUM_PASSES*(SETTLE_CYCLES+2)th rising edge after the edge that samples start (64 at defaults).
REQ-024 On entering DONE, in1 = in2 = 0 and vec_idx = 0; err_count holds its value.
REQ-025 start SHALL be ignored in DRIVE, SETTLE and CHECK.
REQ-026 dut_out SHALL be used only in CHECK; its value in other states has no effect.

Reset
REQ-027 When rst_n = 0, asynchronously: state = IDLE; in1, in2, busy, done, pass = 0; err_count = 0; vec_idx = 0; internal counters = 0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after release begins a fresh run.

Verification
REQ-029 Reset: hold rst_n = 0 with start = 1 -> all outputs 0 and state IDLE; release, start = 0 -> no change.
REQ-030 Ideal gate (dut_out = in1|in2 combinationally), defaults, 1-cycle start pulse -> vectors 00,01,10,11 x4; done rises at edge 64; pass = 1; err_count = 0.
REQ-031 dut_out tied 0, defaults -> err_count = 12, pass = 0; dut_out tied 1 -> err_count = 4, pass = 0.
REQ-032 NUM_PASSES = 100, dut_out tied 0 -> 300 mismatches; err_count saturates at 255 with no wrap.
REQ-033 rst_n pulsed low during SETTLE of vector 2 -> outputs 0 immediately; a new start gives a full 64-cycle run with the correct result.
REQ-034 start held high throughout a run -> no restart before DONE; the start seen in DONE restarts with err_count cleared and done = 0 on the next edge.
